// File: rtl/mmio_pkg.sv
// Shared register map and CTRL/STATUS bit positions for the MMIO responder.
`timescale 1ns/1ps
package mmio_pkg;

    // Word offsets inside the 16-word peripheral window
    typedef enum logic [3:0] {
        REG_LED    = 4'd0,
        REG_SW     = 4'd1,
        REG_TCOUNT = 4'd2,
        REG_TCMP   = 4'd3,
        REG_STATUS = 4'd4,
        REG_CTRL   = 4'd5
    } reg_off_e;

    // CTRL bit positions
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_AUTO   = 1;
    localparam int unsigned CTRL_IRQ_EN = 2;
    localparam int unsigned CTRL_W      = 3;

    // STATUS bit positions
    localparam int unsigned STATUS_MATCH = 0;

    // LED / switch register width
    localparam int unsigned IO_W = 10;

endpackage

// File: rtl/mmio_responder_sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
`timescale 1ns/1ps
module sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmio_responder.sv
// Memory-mapped responder: steers proc accesses to RAM or to a small
// peripheral block (LEDs, switches, timer with compare/auto-reload/irq).
`timescale 1ns/1ps
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [15:0] PERIPH_BASE = 16'hFFF0
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [31:0]     realaddr,
    input  logic [31:0]     dout,
    input  logic            W,
    output logic [31:0]     din,
    input  logic [31:0]     ram_q,
    output logic            ram_we,
    input  logic [IO_W-1:0] sw,
    output logic [IO_W-1:0] ledr,
    output logic            irq
);

    logic [15:0]       waddr;
    logic [3:0]        off;
    logic              hit;
    logic              wr;
    logic              unused_addr;

    logic [IO_W-1:0]   led_q;
    logic [IO_W-1:0]   sw_sync;
    logic [31:0]       tcount_q;
    logic [31:0]       tcount_d;
    logic [31:0]       tcmp_q;
    logic              match_q;
    logic              match_d;
    logic [CTRL_W-1:0] ctrl_q;
    logic              tmatch;

    logic              hit_q;
    logic [31:0]       prdata_q;
    logic [31:0]       rdata;

    assign waddr       = realaddr[17:2];
    assign off         = waddr[3:0];
    assign hit         = (waddr[15:4] == PERIPH_BASE[15:4]);
    assign wr          = W & hit;
    assign unused_addr = ^{realaddr[31:18], realaddr[1:0]};

    assign ram_we = W & ~hit;
    assign din    = hit_q ? prdata_q : ram_q;
    assign ledr   = led_q;
    assign irq    = match_q & ctrl_q[CTRL_IRQ_EN];
    assign tmatch = ctrl_q[CTRL_EN] && (tcount_q == tcmp_q);

    sync2 #(
        .WIDTH(IO_W)
    ) u_sw_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (sw),
        .q      (sw_sync)
    );

    // Read mux over current (pre-write) register values, zero-extended
    always_comb begin
        rdata = '0;
        case (off)
            REG_LED:    rdata = {{(32-IO_W){1'b0}}, led_q};
            REG_SW:     rdata = {{(32-IO_W){1'b0}}, sw_sync};
            REG_TCOUNT: rdata = tcount_q;
            REG_TCMP:   rdata = tcmp_q;
            REG_STATUS: rdata = {31'd0, match_q};
            REG_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
            default:    rdata = '0;
        endcase
    end

    // Timer next state: proc write beats reload/increment, match-set beats W1C
    always_comb begin
        tcount_d = tcount_q;
        match_d  = match_q;
        if (ctrl_q[CTRL_EN]) begin
            tcount_d = (tmatch && ctrl_q[CTRL_AUTO]) ? '0 : tcount_q + 32'd1;
        end
        if (wr && (off == REG_TCOUNT)) begin
            tcount_d = dout;
        end
        if (wr && (off == REG_STATUS) && dout[STATUS_MATCH]) begin
            match_d = 1'b0;
        end
        if (tmatch) begin
            match_d = 1'b1;
        end
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcount_q <= '0;
            match_q  <= 1'b0;
        end else begin
            tcount_q <= tcount_d;
            match_q  <= match_d;
        end
    end

    // Proc-writable configuration registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q  <= '0;
            tcmp_q <= '0;
            ctrl_q <= '0;
        end else if (wr) begin
            if (off == REG_LED)  led_q  <= dout[IO_W-1:0];
            if (off == REG_TCMP) tcmp_q <= dout;
            if (off == REG_CTRL) ctrl_q <= dout[CTRL_W-1:0];
        end
    end

    // One-cycle read pipeline matching the synchronous RAM latency
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hit_q    <= 1'b0;
            prdata_q <= '0;
        end else begin
            hit_q    <= hit;
            prdata_q <= rdata;
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: per-cycle comparison against a
// behavioural register-map model plus directed literal checks.
`timescale 1ns/1ps
module tb_mmio_responder;

    localparam int unsigned BASE = 32'hFFF0;

    localparam logic [31:0] A_LED    = 32'h3FFC0;
    localparam logic [31:0] A_SW     = 32'h3FFC4;
    localparam logic [31:0] A_TCOUNT = 32'h3FFC8;
    localparam logic [31:0] A_TCMP   = 32'h3FFCC;
    localparam logic [31:0] A_STATUS = 32'h3FFD0;
    localparam logic [31:0] A_CTRL   = 32'h3FFD4;
    localparam logic [31:0] A_OFF7   = 32'h3FFDC;
    localparam logic [31:0] A_OFF15  = 32'h3FFFC;

    logic        clk;
    logic        resetn;
    logic [31:0] realaddr;
    logic [31:0] dout;
    logic        W;
    logic [31:0] din;
    logic [31:0] ram_q;
    logic        ram_we;
    logic [9:0]  sw;
    logic [9:0]  ledr;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    mmio_responder #(
        .PERIPH_BASE(16'hFFF0)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .realaddr (realaddr),
        .dout     (dout),
        .W        (W),
        .din      (din),
        .ram_q    (ram_q),
        .ram_we   (ram_we),
        .sw       (sw),
        .ledr     (ledr),
        .irq      (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Small synchronous RAM attached to the RAM side
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        ram_q = '0;
    end
    always @(posedge clk) begin
        if (ram_we) mem[realaddr[9:2]] <= dout;
        ram_q <= mem[realaddr[9:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int unsigned m_led    = 0;
    int unsigned m_tcount = 0;
    int unsigned m_tcmp   = 0;
    bit          m_match  = 0;
    bit          m_en     = 0;
    bit          m_ar     = 0;
    bit          m_ie     = 0;
    int unsigned m_sw1    = 0;
    int unsigned m_sw2    = 0;
    bit          m_rhit   = 0;
    int unsigned m_rdata  = 0;

    function automatic bit in_window(input logic [31:0] a);
        int unsigned w;
        w = int'(a[17:2]);
        return (w >= BASE) && (w < BASE + 16);
    endfunction

    function automatic int unsigned m_read(input int unsigned o);
        case (o)
            0:       return m_led;
            1:       return m_sw2;
            2:       return m_tcount;
            3:       return m_tcmp;
            4:       return m_match ? 1 : 0;
            5:       return (m_ie ? 4 : 0) + (m_ar ? 2 : 0) + (m_en ? 1 : 0);
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge resetn) begin
        int unsigned o;
        int unsigned nxt;
        bit          h;
        bit          wr;
        bit          cmp;
        if (!resetn) begin
            m_led = 0; m_tcount = 0; m_tcmp = 0; m_match = 0;
            m_en = 0; m_ar = 0; m_ie = 0; m_sw1 = 0; m_sw2 = 0;
            m_rhit = 0; m_rdata = 0;
        end else begin
            h  = in_window(realaddr);
            o  = int'(realaddr[17:2]) - BASE;
            wr = W && h;
            m_rhit  = h;
            m_rdata = h ? m_read(o) : 0;
            cmp = m_en && (m_tcount == m_tcmp);
            nxt = m_tcount;
            if (m_en) nxt = (cmp && m_ar) ? 0 : m_tcount + 1;
            if (wr && o == 2) nxt = dout;
            if (cmp) m_match = 1;
            else if (wr && o == 4 && dout[0]) m_match = 0;
            m_tcount = nxt;
            if (wr && o == 0) m_led  = dout & 32'h3FF;
            if (wr && o == 3) m_tcmp = dout;
            if (wr && o == 5) begin
                m_en = dout[0]; m_ar = dout[1]; m_ie = dout[2];
            end
            m_sw2 = m_sw1;
            m_sw1 = int'(sw);
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        logic [31:0] e_din;
        e_din = m_rhit ? m_rdata : ram_q;
        chk("din",    din,          e_din);
        chk("ledr",   32'(ledr),    m_led);
        chk("irq",    32'(irq),     32'(m_match && m_ie));
        chk("ram_we", 32'(ram_we),  32'(W && !in_window(realaddr)));
    end

    // ---------------- stimulus ----------------
    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w);
        realaddr = a;
        dout     = d;
        W        = w;
        @(posedge clk);
        #2;
        W = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(a, d, 1'b1);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus(a, 32'h0, 1'b0);
        chk(name, din, exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus(32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ar_exp [7];
        ar_exp = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0};

        realaddr = '0; dout = '0; W = 1'b0; sw = 10'h2A5;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #1;
        chk("rst_ledr", 32'(ledr), 32'h0);
        chk("rst_irq",  32'(irq),  32'h0);
        chk("rst_din",  din,       ram_q);
        #21 resetn = 1'b1;
        @(posedge clk); #2;

        // LED write: ram_we low that cycle, ledr next cycle, readback one cycle later
        realaddr = A_LED; dout = 32'h3FF; W = 1'b1;
        #1 chk("led_ram_we", 32'(ram_we), 32'h0);
        @(posedge clk); #2; W = 1'b0;
        chk("led_ledr", 32'(ledr), 32'h3FF);
        rd(A_LED, 32'h3FF, "led_read");

        // RAM passthrough
        realaddr = 32'h40; dout = 32'hCAFEBABE; W = 1'b1;
        #1 chk("ram_we_hi", 32'(ram_we), 32'h1);
        @(posedge clk); #2; W = 1'b0;
        rd(32'h40, 32'hCAFEBABE, "ram_read");

        // Timer auto-reload at TCMP=5
        wr(A_TCMP, 32'd5);
        wr(A_TCOUNT, 32'd0);
        wr(A_CTRL, 32'h3);
        for (int i = 0; i < 7; i++) rd(A_TCOUNT, ar_exp[i], "reload_seq");
        chk("reload_irq", 32'(irq), 32'h0);
        rd(A_STATUS, 32'h1, "reload_match");
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);

        // Interrupt, clear in non-match cycle, clear colliding with match
        wr(A_TCOUNT, 32'd0);
        wr(A_TCMP, 32'd2);
        wr(A_CTRL, 32'h5);
        idle(3);
        chk("irq_set", 32'(irq), 32'h1);
        wr(A_STATUS, 32'h1);
        chk("irq_clr", 32'(irq), 32'h0);
        wr(A_TCOUNT, 32'd1);
        idle(1);
        wr(A_STATUS, 32'h1);
        chk("irq_collide", 32'(irq), 32'h1);
        rd(A_STATUS, 32'h1, "status_collide");
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);

        // Wrap and write priority over increment
        wr(A_TCOUNT, 32'hFFFFFFFF);
        wr(A_CTRL, 32'h1);
        rd(A_TCOUNT, 32'hFFFFFFFF, "wrap_pre");
        rd(A_TCOUNT, 32'h0, "wrap_post");
        wr(A_TCOUNT, 32'h10);
        rd(A_TCOUNT, 32'h10, "tcount_wr_prio");

        // Switches, zero-extension, unmapped and read-only offsets
        rd(A_SW, 32'h2A5, "sw_read");
        wr(A_LED, 32'hFFFFFFFF);
        rd(A_LED, 32'h3FF, "led_zext");
        wr(A_OFF7, 32'hDEADBEEF);
        rd(A_OFF7, 32'h0, "off7_read");
        wr(A_SW, 32'h0);
        rd(A_SW, 32'h2A5, "sw_ro");
        rd(A_OFF15, 32'h0, "off15_read");
        rd(A_CTRL, 32'h1, "ctrl_read");

        // Reset in the middle of activity with a read in flight
        sw = 10'h0;
        wr(A_LED, 32'h155);
        wr(A_TCMP, 32'h100);
        wr(A_CTRL, 32'h5);
        wr(A_TCOUNT, 32'h100);
        idle(1);
        chk("pre_rst_irq",  32'(irq),  32'h1);
        chk("pre_rst_ledr", 32'(ledr), 32'h155);
        realaddr = A_LED; W = 1'b0;
        #1 resetn = 1'b0;
        #1;
        chk("async_ledr", 32'(ledr), 32'h0);
        chk("async_irq",  32'(irq),  32'h0);
        #20 resetn = 1'b1;
        @(posedge clk); #2;
        for (int i = 0; i < 6; i++) rd(A_LED + 32'(4 * i), 32'h0, "post_rst_read");

        idle(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
